// File: rtl/dsp_mac_stream.sv
// rtl/dsp_mac_stream.sv - streaming pre-add / multiply / accumulate slice with valid-ready handshake
module dsp_mac_stream #(
    parameter int A_W      = 18,
    parameter int B_W      = 18,
    parameter int C_W      = 48,
    parameter int P_W      = 48,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  RSTN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic signed [A_W-1:0] A,
    input  logic signed [B_W-1:0] B,
    input  logic signed [B_W-1:0] D,
    input  logic signed [C_W-1:0] C,
    input  logic [3:0]            OP,
    input  logic                  LAST,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic signed [P_W-1:0] P,
    output logic                  OVF
);
    localparam int M_W = A_W + B_W + 1;

    logic                  stall;
    logic signed [B_W:0]   b_x, d_x, pre_n;
    logic signed [M_W-1:0] m_n;
    logic [P_W:0]          z_x, m_x, sum_n;
    logic                  ovf_s;
    logic [P_W-1:0]        red_n;

    logic                  s1_v, s1_last;
    logic signed [A_W-1:0] s1_a;
    logic signed [B_W:0]   s1_pre;
    logic signed [C_W-1:0] s1_c;
    logic [3:0]            s1_op;

    logic                  s2_v, s2_last;
    logic signed [M_W-1:0] s2_m;
    logic signed [C_W-1:0] s2_c;
    logic [3:0]            s2_op;

    // acc_r doubles as the S3 result register; s3_v/s3_last say whether it holds a group result
    logic                  s3_v, s3_last;
    logic [P_W-1:0]        acc_r;
    logic                  ovf_r;

    assign stall    = OUT_VALID && !OUT_READY;
    assign IN_READY = !stall;

    always_comb begin
        b_x   = {B[B_W-1], B};
        d_x   = {D[B_W-1], D};
        pre_n = b_x;
        if (OP[0]) begin
            pre_n = OP[1] ? (d_x - b_x) : (d_x + b_x);
        end
    end

    assign m_n = $signed({{(B_W+1){s1_a[A_W-1]}}, s1_a}) * $signed({{A_W{s1_pre[B_W]}}, s1_pre});

    always_comb begin
        z_x   = s2_op[2] ? {acc_r[P_W-1], acc_r} : {{(P_W+1-C_W){s2_c[C_W-1]}}, s2_c};
        m_x   = {{(P_W+1-M_W){s2_m[M_W-1]}}, s2_m};
        sum_n = s2_op[3] ? (z_x - m_x) : (z_x + m_x);
        ovf_s = sum_n[P_W] ^ sum_n[P_W-1];
        red_n = sum_n[P_W-1:0];
        if (SATURATE && ovf_s) begin
            red_n = sum_n[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            s1_v      <= 1'b0;
            s1_last   <= 1'b0;
            s1_a      <= '0;
            s1_pre    <= '0;
            s1_c      <= '0;
            s1_op     <= '0;
            s2_v      <= 1'b0;
            s2_last   <= 1'b0;
            s2_m      <= '0;
            s2_c      <= '0;
            s2_op     <= '0;
            s3_v      <= 1'b0;
            s3_last   <= 1'b0;
            acc_r     <= '0;
            ovf_r     <= 1'b0;
            OUT_VALID <= 1'b0;
            P         <= '0;
            OVF       <= 1'b0;
        end else if (!stall) begin
            s1_v    <= IN_VALID;
            s1_last <= LAST;
            s1_a    <= A;
            s1_pre  <= pre_n;
            s1_c    <= C;
            s1_op   <= OP;

            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_m    <= m_n;
            s2_c    <= s1_c;
            s2_op   <= s1_op;

            s3_v    <= s2_v;
            s3_last <= s2_last;
            if (s2_v) begin
                acc_r <= red_n;
                ovf_r <= ovf_s | (s2_op[2] & ovf_r);
            end

            // Not stalled means the consumer is free or just took P, so clearing is safe
            if (s3_v && s3_last) begin
                P         <= $signed(acc_r);
                OVF       <= ovf_r;
                OUT_VALID <= 1'b1;
            end else begin
                OUT_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_stream.sv
// tb/tb_dsp_mac_stream.sv - directed self-checking bench for dsp_mac_stream
module tb_dsp_mac_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstn, in_valid, out_ready, last;
    logic [3:0]         op;
    logic signed [17:0] a, b, d;
    logic signed [47:0] c;
    logic               in_ready0, in_ready1, ov0, ov1, ovf0, ovf1;
    logic signed [47:0] p0;
    logic signed [36:0] p1;

    int      n_chk = 0;
    int      n_pass = 0;
    bit      rand_ready = 1'b0;
    longint  q0[$], q1[$];
    bit      f0[$], f1[$];

    dsp_mac_stream dut0 (
        .clk(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready0),
        .A(a), .B(b), .D(d), .C(c), .OP(op), .LAST(last),
        .OUT_VALID(ov0), .OUT_READY(out_ready), .P(p0), .OVF(ovf0)
    );

    dsp_mac_stream #(.C_W(37), .P_W(37)) dut1 (
        .clk(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready1),
        .A(a), .B(b), .D(d), .C(c[36:0]), .OP(op), .LAST(last),
        .OUT_VALID(ov1), .OUT_READY(out_ready), .P(p1), .OVF(ovf1)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);

    always @(posedge clk) begin
        if (rstn && out_ready) begin
            if (ov0) begin q0.push_back(p0); f0.push_back(ovf0); end
            if (ov1) begin q1.push_back(p1); f1.push_back(ovf1); end
        end
    end

    task automatic send(input longint ai, input longint bi, input longint di,
                        input longint ci, input logic [3:0] o, input logic l);
        int n = 0;
        bit acc = 1'b0;
        @(negedge clk);
        a = 18'(ai); b = 18'(bi); d = 18'(di); c = 48'(ci);
        op = o; last = l; in_valid = 1'b1;
        do begin
            @(posedge clk);
            acc = in_ready0;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 0, 1);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int k = 0;
        while (q0.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        repeat (6) @(posedge clk);
        #1 check("result_count", q0.size(), n);
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); f0.delete(); f1.delete();
    endtask

    longint bv[5][5] = '{'{3, 4, 0, 1, 0}, '{-5, 6, 0, 0, 0}, '{7, 2, 1, 10, 1},
                         '{1, 1, 0, 0, 3}, '{4, 5, 0, 100, 8}};
    longint bexp[5]  = '{13, -30, 31, -1, 80};

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; last = 1'b0;
        op = '0; a = '0; b = '0; d = '0; c = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", ov0, 0);
        check("rst_p", p0, 0);
        check("rst_ovf", ovf0, 0);
        rstn = 1'b1;

        // Latency and pre-adder / post-adder modes
        send(50, 20, 90, 70, 4'b0001, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("lat_early", ov0, 0);
        @(posedge clk);
        #1 check("lat_valid", ov0, 1);
        check("lat_p", p0, 5570);
        check("lat_ovf", ovf0, 0);
        send(50, 20, 90, 70, 4'b0011, 1'b1);
        send(50, 20, 90, 70, 4'b1011, 1'b1);
        wait_q(3);
        check("mode_add", q0[0], 5570);
        check("mode_presub", q0[1], 3570);
        check("mode_postsub", q0[2], -3430);

        // Two accumulation groups of four
        clear_q();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 4; i++)
                send(2, 3, 0, 0, (i == 0) ? 4'b0000 : 4'b0100, i == 3);
        wait_q(2);
        check("acc_g0", q0[0], 24);
        check("acc_g1", q0[1], 24);

        // Saturation on the 37-bit instance, then a clean group
        clear_q();
        for (int i = 0; i < 6; i++)
            send(131071, 131071, 0, 0, (i == 0) ? 4'b0000 : 4'b0100, i == 5);
        send(2, 3, 0, 0, 4'b0000, 1'b1);
        wait_q(2);
        check("sat_p", q1[0], 64'sd68719476735);
        check("sat_ovf", f1[0], 1);
        check("sat_next_p", q1[1], 6);
        check("sat_next_ovf", f1[1], 0);
        check("wide_p", q0[0], 64'sd103077642246);
        check("wide_ovf", f0[0], 0);

        // Backpressure while streaming six results
        clear_q();
        fork
            for (int i = 0; i < 6; i++) send(i + 1, 10, 0, 0, 4'b0000, 1'b1);
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    #1;
                    check("bp_in_ready", in_ready0, 0);
                    check("bp_hold_p", p0, 10);
                end
                out_ready = 1'b1;
            end
        join
        wait_q(6);
        for (int i = 0; i < 6; i++) check($sformatf("bp_res%0d", i), q0[i], 10 * (i + 1));

        // Bubbles with random consumer readiness
        clear_q();
        rand_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(bv[i][0], bv[i][1], bv[i][2], bv[i][3], 4'(bv[i][4]), 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        wait_q(5);
        for (int i = 0; i < 5; i++) check($sformatf("bub_res%0d", i), q0[i], bexp[i]);

        // Reset in the middle of a group with a result pending
        clear_q();
        out_ready = 1'b0;
        send(2, 3, 0, 1, 4'b0000, 1'b1);
        send(2, 3, 0, 0, 4'b0000, 1'b0);
        send(2, 3, 0, 0, 4'b0100, 1'b0);
        @(posedge clk);
        #2 check("pre_rst_valid", ov0, 1);
        check("pre_rst_p", p0, 7);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", ov0, 0);
        check("mid_rst_p", p0, 0);
        check("mid_rst_ovf", ovf0, 0);
        check("mid_rst_in_ready", in_ready0, 1);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            send(2, 3, 0, 0, (i == 0) ? 4'b0000 : 4'b0100, i == 3);
        wait_q(1);
        check("post_rst_sum", q0[0], 24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dsp_mac_stream.md
# dsp_mac_stream

Parametrised, streaming successor to the DSP48A1 slice. It provides a signed pre-adder, a multiplier and a post-adder/accumulator behind a valid/ready handshake. Widths are set per instance, and the result can saturate with an overflow flag. Accumulation groups are delimited by a LAST flag carried with each sample. The block sits between sample sources (filter taps, coefficient ROMs) and downstream result consumers. It replaces hand-wired DSP48A1 instances wherever backpressure or grouped accumulation is needed.

## Interface
- A_W, 18, width of signed multiplicand A
- B_W, 18, width of signed B and D (pre-adder operands)
- C_W, 48, width of signed C addend
- P_W, 48, width of signed result P; must satisfy P_W ≥ A_W+B_W+1 and P_W ≥ C_W
- SATURATE, 1, 1 = clamp result to P_W signed range; 0 = wrap modulo 2^P_W
---
- clk, in, 1, rising-edge clock
- RSTN, in, 1, reset, asynchronous and active-low
- IN_VALID, in, 1, input sample valid
- IN_READY, out, 1, block can accept a sample this cycle
- A, in, A_W, signed
- B, in, B_W, signed
- D, in, B_W, signed
- C, in, C_W, signed
- OP, in, 4, per-sample mode: bit0 PREADD_EN, bit1 PRESUB, bit2 ACC, bit3 POSTSUB
- LAST, in, 1, sample closes the current accumulation group
- OUT_VALID, out, 1, P valid
- OUT_READY, in, 1, consumer accepts P
- P, out, P_W, signed result
- OVF, out, 1, saturation or wrap occurred within the reported group; valid with OUT_VALID

## Operation
- A sample is accepted on a rising edge when IN_VALID && IN_READY.
- Stage 1 (S1) registers A, C, OP, LAST and the pre-adder result PRE:
  - PREADD_EN=0: PRE = B.
  - PREADD_EN=1, PRESUB=0: PRE = D + B.
  - PREADD_EN=1, PRESUB=1: PRE = D − B.
  - PRE is B_W+1 bits, sign-extended, and never overflows.
- Stage 2 (S2) registers M = A × PRE, signed, A_W+B_W+1 bits.
- Stage 3 (S3) computes Z ± M and writes it into the accumulator register ACC_R.
  - Z = ACC_R when ACC=1, else C sign-extended.
  - The operator is − when POSTSUB=1, else +.
  - The sum is computed in P_W+1 bits and then reduced to P_W bits:
    - SATURATE=1: clamp to [−2^(P_W−1), 2^(P_W−1)−1].
    - SATURATE=0: truncate.
  - Per-group overflow flag OVF_R: ovf_sample | (ACC ? OVF_R : 0).
- Output for a sample with LAST=1:
  - P ← reduced result, OVF ← OVF_R value.
  - OUT_VALID is set.
  - The next ACC=1 sample accumulates from the reduced result. Using ACC=0 to start a group is mandatory.
- Samples with LAST=0 update ACC_R only and produce no output.
- Stall rule:
  - stall = OUT_VALID && !OUT_READY.
  - On stall, every stage register holds its value.
  - IN_READY = !stall.
  - OUT_VALID clears on the handshake unless a new LAST result lands in the same cycle.
- Reset mid-operation: all in-flight samples are discarded, and the partial group in ACC_R is lost.

## Timing
- Reset values: IN_READY=1, OUT_VALID=0, P=0, OVF=0, ACC_R=0, and all stage-valid bits 0.
- Latency: a sample accepted at edge k with LAST=1 gives OUT_VALID=1 after edge k+3, assuming no stall.
- Throughput is one sample per cycle while OUT_READY=1 or OUT_VALID=0.
- P and OVF are stable from OUT_VALID rising until the handshake.
- IN_READY is combinational from OUT_VALID and OUT_READY only. It does not depend on IN_VALID.
- Bubbles (IN_VALID=0) propagate as invalid stages; invalid stages never modify ACC_R.
- Back-to-back LAST results stream at full rate.
- A result landing in S3 during a stall waits in S3 and does not overwrite P.
- Simultaneous OUT_READY handshake and new S3 result: P updates and OUT_VALID stays 1.
- RSTN assertion takes effect immediately and asynchronously on all registers. Release is synchronised externally.

## Test plan
- Single sample, default widths: A=50, B=20, D=90, C=70, OP=0b0001, LAST=1. Required: P=5570, OVF=0, 3 cycles after accept. With OP=0b0011: P=3570. With OP=0b1011: P=−3430.
- Accumulation: 4 samples A=2, B=3, OP=0b0100 (the first with OP=0b0000, C=0), LAST only on the 4th. Required: exactly one output, P=24. A second group of the same samples also gives 24.
- Saturation, instance P_W=37: accumulate A=2^17−1, B=2^17−1 repeatedly. Required: P clamps to 2^36−1 and OVF=1. The following group without overflow reports OVF=0.
- Backpressure: stream 6 LAST samples with OUT_READY=0 from cycle 4 to cycle 9. Required:
  - IN_READY=0 and P held constant throughout.
  - All 6 results are delivered in order after release, with none lost or duplicated.
- Bubbles: alternating IN_VALID=1/0 with random OUT_READY. Required: results match the reference model in order.
- Reset mid-group: assert RSTN low after 2 of 4 accumulating samples. Required:
  - All outputs return to reset values immediately.
  - A fresh group after release gives the correct sum with no residue from before reset.
